// File: rtl/can_crc_if.sv
// Bus interface for can_crc_engine.
// Carries frame control (start/abort/last), the data beat and its valid, and
// the status returned by the engine (busy, crc_done, crc_out, crc_ok, beat_cnt).
// master: the frame source (TX/RX framer or testbench).
// slave : the CRC engine.
interface can_crc_if #(
    parameter int unsigned CRC_W  = 15,
    parameter int unsigned DATA_W = 1,
    parameter int unsigned CNT_W  = 16
) ();

    // frame control and data, driven by the master
    logic              start;
    logic              abort;
    logic              data_valid;
    logic              last;
    logic [DATA_W-1:0] data_in;

    // status, driven by the engine
    logic              busy;
    logic              crc_done;
    logic              crc_ok;
    logic [CRC_W-1:0]  crc_out;
    logic [CNT_W-1:0]  beat_cnt;

    modport master (
        output start,
        output abort,
        output data_valid,
        output last,
        output data_in,
        input  busy,
        input  crc_done,
        input  crc_ok,
        input  crc_out,
        input  beat_cnt
    );

    modport slave (
        input  start,
        input  abort,
        input  data_valid,
        input  last,
        input  data_in,
        output busy,
        output crc_done,
        output crc_ok,
        output crc_out,
        output beat_cnt
    );

endinterface

// File: rtl/can_crc_engine.sv
// Parametrised CRC generator/checker for the CAN TX/RX paths.
// Folds DATA_W bits per accepted beat into a CRC_W-bit register, MSB first,
// with frames delimited by start/last and cancelled by abort.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - can_crc_if.slave: start, abort, data_valid, last, data_in in;
//          busy, crc_done, crc_out, crc_ok, beat_cnt out (all registered)
module can_crc_engine #(
    parameter int unsigned       CRC_W   = 15,
    parameter logic [CRC_W-1:0]  POLY    = CRC_W'(15'h4599),
    parameter logic [CRC_W-1:0]  INIT    = '0,
    parameter logic [CRC_W-1:0]  XOR_OUT = '0,
    parameter logic [CRC_W-1:0]  RESIDUE = '0,
    parameter int unsigned       DATA_W  = 1,
    parameter int unsigned       CNT_W   = 16
) (
    input  logic      clk,
    input  logic      rst,
    can_crc_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [CRC_W-1:0]  crc_reg;
    logic [CRC_W-1:0]  crc_nxt;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_nxt;

    logic              busy_reg;
    logic              done_reg;
    logic              ok_reg;
    logic [CRC_W-1:0]  crc_out_reg;

    logic              busy_nxt;
    logic              done_nxt;
    logic              ok_nxt;
    logic [CRC_W-1:0]  crc_out_nxt;

    // One full beat of the serial LFSR step, unrolled DATA_W times, MSB first.
    function automatic logic [CRC_W-1:0] crc_step(
        input logic [CRC_W-1:0]  crc_in,
        input logic [DATA_W-1:0] data
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data[i];
            c  = {c[CRC_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ POLY;
            end
        end
        return c;
    endfunction

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            crc_reg     <= INIT;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            ok_reg      <= 1'b0;
            crc_out_reg <= INIT ^ XOR_OUT;
        end else begin
            state       <= state_nxt;
            crc_reg     <= crc_nxt;
            cnt_reg     <= cnt_nxt;
            busy_reg    <= busy_nxt;
            done_reg    <= done_nxt;
            ok_reg      <= ok_nxt;
            crc_out_reg <= crc_out_nxt;
        end
    end

    // Next state and datapath: abort beats start beats data_valid.
    always_comb begin
        state_nxt = state;
        crc_nxt   = crc_reg;
        cnt_nxt   = cnt_reg;

        if (bus.abort) begin
            state_nxt = IDLE;
            crc_nxt   = INIT;
            cnt_nxt   = '0;
        end else if (bus.start) begin
            // a beat arriving with start is folded onto INIT, not the old value
            if (bus.data_valid) begin
                crc_nxt   = crc_step(INIT, bus.data_in);
                cnt_nxt   = CNT_ONE;
                state_nxt = bus.last ? DONE : ACCUM;
            end else begin
                crc_nxt   = INIT;
                cnt_nxt   = '0;
                state_nxt = ACCUM;
            end
        end else begin
            unique case (state)
                ACCUM: begin
                    if (bus.data_valid) begin
                        crc_nxt = crc_step(crc_reg, bus.data_in);
                        // counter saturates; the CRC keeps folding regardless
                        cnt_nxt = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
                        if (bus.last) begin
                            state_nxt = DONE;
                        end
                    end
                end
                IDLE, DONE: begin
                    // beats are ignored outside a frame; everything holds
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so the flags are registered.
    always_comb begin
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        ok_nxt      = 1'b0;
        crc_out_nxt = crc_nxt ^ XOR_OUT;

        busy_nxt = (state_nxt == ACCUM);
        done_nxt = (state_nxt == DONE);
        ok_nxt   = done_nxt && (crc_nxt == RESIDUE);
    end

    assign bus.busy     = busy_reg;
    assign bus.crc_done = done_reg;
    assign bus.crc_ok   = ok_reg;
    assign bus.crc_out  = crc_out_reg;
    assign bus.beat_cnt = cnt_reg;

endmodule

// File: tb/tb_can_crc_engine.sv
// Directed testbench for can_crc_engine.
// Four instances: default serial CAN CRC-15, CRC-15 byte-wide, CRC-32/BZIP2
// byte-wide, and a serial CRC-15 with a 2-bit beat counter that shares the
// serial stimulus.
module tb_can_crc_engine;

    logic clk;
    logic rst;

    int checks;
    int errors;

    logic [7:0]  bytes [64];
    logic [14:0] exp15;
    logic [7:0]  byt;
    logic        first;
    logic        lst;
    logic [14:0] pat;
    logic [4:0]  bits5;

    can_crc_if #(.CRC_W(15), .DATA_W(1), .CNT_W(16)) if1 ();
    can_crc_if #(.CRC_W(15), .DATA_W(1), .CNT_W(2))  ifc ();
    can_crc_if #(.CRC_W(15), .DATA_W(8), .CNT_W(16)) if8 ();
    can_crc_if #(.CRC_W(32), .DATA_W(8), .CNT_W(16)) if32 ();

    can_crc_engine #(.CRC_W(15), .DATA_W(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    can_crc_engine #(.CRC_W(15), .DATA_W(1), .CNT_W(2)) dutc (
        .clk(clk), .rst(rst), .bus(ifc)
    );

    can_crc_engine #(.CRC_W(15), .DATA_W(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .bus(if8)
    );

    can_crc_engine #(
        .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .XOR_OUT(32'hFFFFFFFF), .RESIDUE(32'h0), .DATA_W(8), .CNT_W(16)
    ) dut32 (
        .clk(clk), .rst(rst), .bus(if32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference serial CAN CRC-15 step (x^15+x^14+x^10+x^8+x^7+x^4+x^3+1).
    function automatic logic [14:0] m_step(input logic [14:0] c, input logic d);
        logic        fb;
        logic [14:0] s;
        fb = c[14] ^ d;
        s  = {c[13:0], 1'b0};
        return fb ? (s ^ 15'h4599) : s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of serial stimulus on the two serial engines, sampled #1 after the edge.
    task automatic step1(input logic st, input logic ab, input logic dv,
                         input logic ls, input logic d);
        if1.start = st; if1.abort = ab; if1.data_valid = dv; if1.last = ls; if1.data_in = d;
        ifc.start = st; ifc.abort = ab; ifc.data_valid = dv; ifc.last = ls; ifc.data_in = d;
        @(posedge clk);
        #1;
    endtask

    // One clock of byte stimulus on the two byte-wide engines.
    task automatic step8(input logic st, input logic ab, input logic dv,
                         input logic ls, input logic [7:0] d);
        if8.start = st;  if8.abort = ab;  if8.data_valid = dv;  if8.last = ls;  if8.data_in = d;
        if32.start = st; if32.abort = ab; if32.data_valid = dv; if32.last = ls; if32.data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        step1(0, 0, 0, 0, 0);
        step8(0, 0, 0, 0, 8'h00);

        // reset state
        chk("rst_busy",    32'(if1.busy), 32'd0);
        chk("rst_done",    32'(if1.crc_done), 32'd0);
        chk("rst_ok",      32'(if1.crc_ok), 32'd0);
        chk("rst_crc",     32'(if1.crc_out), 32'h0);
        chk("rst_cnt",     32'(if1.beat_cnt), 32'd0);
        chk("rst_crc32",   if32.crc_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // single-bit frame
        step1(1, 0, 1, 1, 1);
        chk("one_done", 32'(if1.crc_done), 32'd1);
        chk("one_busy", 32'(if1.busy), 32'd0);
        chk("one_crc",  32'(if1.crc_out), 32'h4599);
        chk("one_cnt",  32'(if1.beat_cnt), 32'd1);
        chk("one_ok",   32'(if1.crc_ok), 32'd0);

        // data_valid in DONE is ignored
        step1(0, 0, 1, 1, 0);
        chk("done_hold_crc", 32'(if1.crc_out), 32'h4599);
        chk("done_hold_cnt", 32'(if1.beat_cnt), 32'd1);
        chk("done_hold_st",  32'(if1.crc_done), 32'd1);

        // two-bit frame
        step1(1, 0, 1, 0, 1);
        chk("two_a_done", 32'(if1.crc_done), 32'd0);
        chk("two_a_busy", 32'(if1.busy), 32'd1);
        chk("two_a_crc",  32'(if1.crc_out), 32'h4599);
        step1(0, 0, 1, 1, 0);
        chk("two_b_done", 32'(if1.crc_done), 32'd1);
        chk("two_b_crc",  32'(if1.crc_out), 32'h4EAB);
        chk("two_b_cnt",  32'(if1.beat_cnt), 32'd2);

        // start in DONE opens a fresh frame
        step1(1, 0, 0, 0, 0);
        chk("restart_busy", 32'(if1.busy), 32'd1);
        chk("restart_done", 32'(if1.crc_done), 32'd0);
        chk("restart_crc",  32'(if1.crc_out), 32'h0);
        chk("restart_cnt",  32'(if1.beat_cnt), 32'd0);

        // residue check: 1 followed by the 15 CRC bits
        pat = 15'h4599;
        step1(1, 0, 1, 0, 1);
        for (int i = 14; i >= 0; i--) begin
            step1(0, 0, 1, (i == 0), pat[i]);
        end
        chk("res_crc",  32'(if1.crc_out), 32'h0);
        chk("res_ok",   32'(if1.crc_ok), 32'd1);
        chk("res_cnt",  32'(if1.beat_cnt), 32'd16);

        // same stream with one bit flipped
        pat = 15'h4599 ^ 15'h0080;
        step1(1, 0, 1, 0, 1);
        for (int i = 14; i >= 0; i--) begin
            step1(0, 0, 1, (i == 0), pat[i]);
        end
        chk("flip_done", 32'(if1.crc_done), 32'd1);
        chk("flip_ok",   32'(if1.crc_ok), 32'd0);

        // abort+start+data_valid in ACCUM
        step1(1, 0, 1, 0, 1);
        step1(1, 1, 1, 0, 1);
        chk("abort_busy", 32'(if1.busy), 32'd0);
        chk("abort_done", 32'(if1.crc_done), 32'd0);
        chk("abort_crc",  32'(if1.crc_out), 32'h0);
        chk("abort_cnt",  32'(if1.beat_cnt), 32'd0);

        // data_valid in IDLE is ignored
        step1(0, 0, 1, 1, 1);
        chk("idle_crc",  32'(if1.crc_out), 32'h0);
        chk("idle_cnt",  32'(if1.beat_cnt), 32'd0);
        chk("idle_done", 32'(if1.crc_done), 32'd0);

        // 5-beat frame: 2-bit counter saturates, CRC keeps folding
        bits5 = 5'b10110;
        exp15 = '0;
        for (int i = 4; i >= 0; i--) begin
            exp15 = m_step(exp15, bits5[i]);
            step1((i == 4), 0, 1, (i == 0), bits5[i]);
        end
        chk("sat_cnt",     32'(ifc.beat_cnt), 32'd3);
        chk("sat_cnt_ref", 32'(if1.beat_cnt), 32'd5);
        chk("sat_crc",     32'(ifc.crc_out), 32'(exp15));

        // async reset between edges mid-ACCUM
        step1(1, 0, 1, 0, 1);
        step1(0, 0, 1, 0, 1);
        step1(0, 0, 0, 0, 0);
        chk("pre_rst_busy", 32'(if1.busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(if1.busy), 32'd0);
        chk("arst_crc",  32'(if1.crc_out), 32'h0);
        chk("arst_cnt",  32'(if1.beat_cnt), 32'd0);
        #1 rst = 1'b0;

        // serial vs byte-wide over a random 64-byte stream with gaps
        for (int i = 0; i < 64; i++) begin
            bytes[i] = 8'($urandom);
        end
        exp15 = '0;
        first = 1'b1;
        for (int i = 0; i < 64; i++) begin
            byt = bytes[i];
            for (int b = 7; b >= 0; b--) begin
                lst = (i == 63) && (b == 0);
                exp15 = m_step(exp15, byt[b]);
                step1(first, 0, 1, lst, byt[b]);
                first = 1'b0;
                if (!lst && ($urandom_range(0, 3) == 0)) begin
                    step1(0, 0, 0, 0, 0);
                end
            end
        end
        step1(0, 0, 0, 0, 0);
        chk("ser_done", 32'(if1.crc_done), 32'd1);
        chk("ser_crc",  32'(if1.crc_out), 32'(exp15));
        chk("ser_cnt",  32'(if1.beat_cnt), 32'd512);

        first = 1'b1;
        for (int i = 0; i < 64; i++) begin
            lst = (i == 63);
            step8(first, 0, 1, lst, bytes[i]);
            first = 1'b0;
            if (!lst && ($urandom_range(0, 2) == 0)) begin
                step8(0, 0, 0, 0, 8'h00);
            end
        end
        step8(0, 0, 0, 0, 8'h00);
        chk("par_done", 32'(if8.crc_done), 32'd1);
        chk("par_crc",  32'(if8.crc_out), 32'(exp15));
        chk("par_cnt",  32'(if8.beat_cnt), 32'd64);

        // CRC-32/BZIP2 check value over "123456789"
        for (int i = 0; i < 9; i++) begin
            step8((i == 0), 0, 1, (i == 8), 8'(8'h31 + i));
        end
        step8(0, 0, 0, 0, 8'h00);
        chk("c32_done", 32'(if32.crc_done), 32'd1);
        chk("c32_crc",  if32.crc_out, 32'hFC891918);
        chk("c32_cnt",  32'(if32.beat_cnt), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_crc_engine.md
Name: can_crc_engine

Overview:
- Parametrised CRC generator/checker; successor to the fixed 15-bit serial CAN CRC.
- Supports configurable CRC width, polynomial, init value and output XOR.
- Folds DATA_W bits per clock, MSB first, and frames each computation with start/last/abort.
- Reports the final CRC, a residue-check result and a beat count. Used in the CAN TX path to generate the CRC and in the RX path to check it.

Parameters:
- CRC_W, 15, CRC register width (2..32).
- POLY, 15'h4599, generator polynomial without the implicit x^CRC_W term; CRC_W bits.
- INIT, 0, register value loaded on start/abort/reset; CRC_W bits.
- XOR_OUT, 0, XOR applied to the register to form crc_out; CRC_W bits.
- RESIDUE, 0, expected register value after a frame that includes its received CRC; CRC_W bits.
- DATA_W, 1, bits folded per accepted beat (1..64). data_in[DATA_W-1] is processed first.
- CNT_W, 16, beat counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a frame. Loads INIT; a beat presented in the same cycle is folded onto INIT.
- abort  in  1  discards the frame and returns to IDLE.
- data_valid  in  1  data_in is valid this cycle.
- data_in  in  DATA_W  data beat.
- last  in  1  qualifies the final beat of the frame; ignored unless data_valid=1.
- busy  out  1  high in ACCUM.
- crc_done  out  1  high (level) in DONE.
- crc_out  out  CRC_W  crc_reg ^ XOR_OUT; always driven.
- crc_ok  out  1  (crc_reg == RESIDUE) && crc_done.
- beat_cnt  out  CNT_W  beats accepted in the current/last frame; saturates at all-ones.

Behaviour:
- Step function for bit d, iterated DATA_W times from MSB to LSB:
  - fb = crc[CRC_W-1] ^ d
  - crc = (crc << 1) truncated to CRC_W bits
  - if fb: crc ^= POLY
- The whole step is combinational within one cycle, so latency is 1 clock from an accepted beat to crc_reg.
- Reset (asynchronous):
  - state = IDLE, crc_reg = INIT, beat_cnt = 0.
  - Outputs: busy = 0, crc_done = 0, crc_ok = 0, crc_out = INIT ^ XOR_OUT.
- States: IDLE, ACCUM, DONE.
- Priority each cycle: abort > start > data_valid.
- abort in any state:
  - next state IDLE, crc_reg = INIT, beat_cnt = 0.
  - A simultaneous start or data beat is dropped.
- start in any state (no abort): always restarts.
  - Without data_valid: crc_reg = INIT, beat_cnt = 0, next state ACCUM.
  - With data_valid and !last: crc_reg = step(INIT, data_in), beat_cnt = 1, next state ACCUM.
  - With data_valid and last: crc_reg = step(INIT, data_in), beat_cnt = 1, next state DONE (single-beat frame).
- IDLE without start: data_valid and last are ignored; registers hold.
- ACCUM, data_valid=1: crc_reg = step(crc_reg, data_in), beat_cnt += 1 (saturating). If last=1, next state DONE.
- ACCUM, data_valid=0: everything holds, with no timeout.
- DONE:
  - crc_reg and beat_cnt freeze.
  - data_valid and last are ignored.
  - Remains in DONE until start or abort.
- crc_done and crc_ok first assert in the cycle after the last beat is accepted.
- beat_cnt at all-ones stays at all-ones; the CRC keeps accumulating normally.
- Reset asserted mid-frame clears immediately, asynchronously, to the reset values above.

Test Plan:
- Default params, serial single-bit frame: start+data_valid+last with data_in=1 -> next cycle crc_done=1, crc_out=15'h4599, beat_cnt=1, crc_ok=0.
- Default params, two bits: start with 1, then last with 0 -> crc_out=15'h4EAB, beat_cnt=2; crc_done is low after the first bit and high after the second.
- Residue check: bit 1, then the 15 bits of 15'h4599 MSB first with last on the 15th -> crc_out=0, crc_ok=1, beat_cnt=16. Flip any single bit in the same stream -> crc_ok=0.
- Width/parallel equivalence: DATA_W=8 vs DATA_W=1 over the same random 64-byte stream, with random gaps in data_valid -> identical crc_out at DONE. Repeat with CRC_W=32, POLY=32'h04C11DB7, INIT=32'hFFFFFFFF, XOR_OUT=32'hFFFFFFFF: "123456789" gives crc_out=32'hFC891918 (non-reflected CRC-32/BZIP2 check value).
- Control priority, all three cases:
  - abort+start+data_valid in ACCUM -> IDLE, crc_out=INIT^XOR_OUT, beat_cnt=0.
  - start in DONE -> ACCUM with a fresh frame.
  - data_valid in IDLE or DONE -> no change.
- Async reset pulsed mid-ACCUM between clock edges -> outputs reach reset values before the next edge. CNT_W=2 frame of 5 beats -> beat_cnt=3.
